// File: rtl/axi4l_ram_slave.sv
// axi4l_ram_slave: AXI4-Lite slave that fronts a word-organised on-chip RAM.
// Write and read paths are independent, with at most one transaction in flight per path.
// AW and W are each captured into their own holding register and may arrive in any order.
// A write commits once both registers are full and no B response is still waiting.
// Reads respond one cycle after the AR handshake.
// Addresses at or beyond DEPTH*4 complete with SLVERR: writes leave the RAM unchanged and reads return zero.
// Optional feature (define AXI4L_RAM_PROT_EN): unprivileged accesses (prot[0]=0) complete with SLVERR.
module axi4l_ram_slave #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // write address channel
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [2:0]            awprot,
    // write data channel
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    // write response channel
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    // read address channel
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [2:0]            arprot,
    // read data channel
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp
);

    localparam int          IDX_W  = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    // write-path holding registers
    logic              aw_full;
    logic              aw_ok;
    logic [IDX_W-1:0]  aw_idx;
    logic              w_full;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              commit;

    // address decode
    logic              aw_in_range;
    logic              ar_in_range;
    logic              aw_ok_in;
    logic              ar_ok_in;
    logic [IDX_W-1:0]  ar_idx;

    logic [0:0]        r_state;
    logic              unused_bits;

    assign aw_in_range = (awaddr[ADDR_W-1:IDX_W+2] == '0);
    assign ar_in_range = (araddr[ADDR_W-1:IDX_W+2] == '0);
    assign ar_idx      = araddr[2 +: IDX_W];

`ifdef AXI4L_RAM_PROT_EN
    assign aw_ok_in = aw_in_range & awprot[0];
    assign ar_ok_in = ar_in_range & arprot[0];
`else
    assign aw_ok_in = aw_in_range;
    assign ar_ok_in = ar_in_range;
`endif

    // byte-lane address bits and (depending on build) prot bits carry no meaning here
    assign unused_bits = &{1'b0, awaddr[1:0], araddr[1:0], awprot, arprot};

    // readies are gated by aresetn so nothing handshakes while reset is asserted
    assign awready = aresetn & ~aw_full;
    assign wready  = aresetn & ~w_full;
    assign arready = aresetn & (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);

    // a write may only commit while no B response is still waiting to be accepted
    assign commit  = aw_full & w_full & ~bvalid;

    // capture AW/W into their holding registers, commit, and hold B until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            aw_ok   <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_idx  <= awaddr[2 +: IDX_W];
                aw_ok   <= aw_ok_in;
            end else if (commit) begin
                aw_full <= 1'b0;
            end

            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end

            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // byte-masked RAM write on commit; RAM contents are never reset
    always_ff @(posedge aclk) begin
        if (commit && aw_ok) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // read FSM: accept AR in R_IDLE, hold the response in R_RESP until rready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state <= R_RESP;
                        rdata   <= ar_ok_in ? mem[ar_idx] : '0;
                        rresp   <= ar_ok_in ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_ram_slave.sv
// tb_axi4l_ram_slave: self-checking bench for axi4l_ram_slave.
// Checks reset state, write/read latency, byte strobes, the out-of-range boundary, back-pressure,
// reset in the middle of a transaction, prot handling, and a randomized access mix.
// Every expected value comes from a word-array reference model held in this bench.
// Prot expectations follow AXI4L_RAM_PROT_EN when the bench is built with that macro.
module tb_axi4l_ram_slave;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 50;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic              aclk;
    logic              aresetn;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [DEPTH];

    axi4l_ram_slave #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- reference model ----------------
    function automatic bit addr_ok(input logic [31:0] a, input logic [2:0] p);
        bit ok;
        ok = (a < 32'(DEPTH * 4));
`ifdef AXI4L_RAM_PROT_EN
        ok = ok && p[0];
`else
        if (p[0] === 1'bx) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        if (addr_ok(a, p)) model[widx(a)] = merge(model[widx(a)], d, s);
    endtask

    // ---------------- bus drivers (called at a negedge, return at a negedge) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat, output bit to);
        int t;
        bit aw_done, w_done, aw_hs, w_hs;
        t = 0; aw_done = 0; w_done = 0; to = 0; lat = 0; resp = 2'bxx;
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && !to) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge aclk);
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            t++;
            if (t > TO) to = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!to) begin
            lat = 1;
            while (!bvalid && lat < TO) begin
                @(negedge aclk);
                lat++;
            end
            if (!bvalid) to = 1;
            resp = bresp;
            @(negedge aclk);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp, output int lat, output bit to);
        int t;
        bit hs;
        t = 0; hs = 0; to = 0; lat = 0; data = 'x; resp = 2'bxx;
        araddr = addr; arprot = prot; rready = 1'b1;
        while (!hs && !to) begin
            arvalid = 1'b1;
            hs = arready;
            @(negedge aclk);
            t++;
            if (!hs && t > TO) to = 1;
        end
        arvalid = 1'b0;
        if (!to) begin
            lat = 1;
            while (!rvalid && lat < TO) begin
                @(negedge aclk);
                lat++;
            end
            if (!rvalid) to = 1;
            data = rdata;
            resp = rresp;
            @(negedge aclk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        n_tests++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++; $display("FAIL reset_hs: got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
        n_tests++; if ({bresp, rresp} !== 4'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp}); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_tests++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 111", {awready, wready, arready}); end
        @(negedge aclk);
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b001);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_wr_timeout: got %b expected 0", to); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL basic_wr_latency: got %0d expected 2", lat); end
        n_tests++; if (resp !== OKAY) begin n_fail++; $display("FAIL basic_bresp: got %b expected %b", resp, OKAY); end
        axi_read(32'h10, 3'b001, d, resp, lat, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_rd_timeout: got %b expected 0", to); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL basic_rd_latency: got %0d expected 1", lat); end
        n_tests++; if (d !== model[widx(32'h10)]) begin n_fail++; $display("FAIL basic_rdata: got %h expected %h", d, model[widx(32'h10)]); end
        n_tests++; if (resp !== OKAY) begin n_fail++; $display("FAIL basic_rresp: got %b expected %b", resp, OKAY); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        awaddr = 32'h10; awprot = 3'b001; wdata = 32'h11223344; wstrb = 4'b0101;
        wvalid = 1'b1;
        n_tests++; if (wready !== 1'b1) begin n_fail++; $display("FAIL strb_wready_empty: got %b expected 1", wready); end
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++; if ({awready, wready, bvalid} !== 3'b100) begin n_fail++; $display("FAIL strb_wait_cycle%0d: got %b expected 100", i, {awready, wready, bvalid}); end
            @(negedge aclk);
        end
        awvalid = 1'b1;
        n_tests++; if (awready !== 1'b1) begin n_fail++; $display("FAIL strb_awready: got %b expected 1", awready); end
        @(negedge aclk);
        awvalid = 1'b0;
        n_tests++; if ({awready, bvalid} !== 2'b00) begin n_fail++; $display("FAIL strb_aw_full: got %b expected 00", {awready, bvalid}); end
        @(negedge aclk);
        model_write(32'h10, 32'h11223344, 4'b0101, 3'b001);
        n_tests++; if ({awready, wready, bvalid, bresp} !== {3'b111, OKAY}) begin n_fail++; $display("FAIL strb_commit: got %b expected %b", {awready, wready, bvalid, bresp}, {3'b111, OKAY}); end
        @(negedge aclk);
        axi_read(32'h10, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[widx(32'h10)] || to) begin n_fail++; $display("FAIL strb_rdata: got %h expected %h", d, model[widx(32'h10)]); end
    endtask

    task automatic test_range();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        axi_write(32'h0, 32'hA5A50F0F, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h0, 32'hA5A50F0F, 4'hF, 3'b001);
        axi_write(32'(DEPTH * 4), 32'h12345678, 4'hF, 3'b001, 0, 0, resp, lat, to);
        n_tests++; if (resp !== SLVERR || to) begin n_fail++; $display("FAIL range_bresp: got %b expected %b", resp, SLVERR); end
        axi_read(32'(DEPTH * 4), 3'b001, d, resp, lat, to);
        n_tests++; if ({d, resp} !== {32'h0, SLVERR} || to) begin n_fail++; $display("FAIL range_read: got %h/%b expected 00000000/%b", d, resp, SLVERR); end
        axi_read(32'h0, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[0]) begin n_fail++; $display("FAIL range_alias_unchanged: got %h expected %h", d, model[0]); end
        axi_write(32'(DEPTH * 4 - 4), 32'hCAFEF00D, 4'hF, 3'b001, 1, 0, resp, lat, to);
        model_write(32'(DEPTH * 4 - 4), 32'hCAFEF00D, 4'hF, 3'b001);
        n_tests++; if (resp !== OKAY || to) begin n_fail++; $display("FAIL range_last_bresp: got %b expected %b", resp, OKAY); end
        axi_read(32'(DEPTH * 4 - 4), 3'b001, d, resp, lat, to);
        n_tests++; if ({d, resp} !== {model[DEPTH-1], OKAY}) begin n_fail++; $display("FAIL range_last_read: got %h/%b expected %h/%b", d, resp, model[DEPTH-1], OKAY); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        axi_write(32'h24, 32'h0BADF00D, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h24, 32'h0BADF00D, 4'hF, 3'b001);
        bready = 1'b0;
        axi_write(32'h20, 32'h55AA33CC, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h20, 32'h55AA33CC, 4'hF, 3'b001);
        // second write offered while the first B is still held
        awaddr = 32'h24; wdata = 32'h77665544; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n_tests++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL bp_second_ready: got %b expected 11", {awready, wready}); end
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({bvalid, bresp, awready, wready} !== {1'b1, OKAY, 2'b00}) begin n_fail++; $display("FAIL bp_hold_cycle%0d: got %b expected %b", i, {bvalid, bresp, awready, wready}, {1'b1, OKAY, 2'b00}); end
            @(negedge aclk);
        end
        axi_read(32'h24, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[widx(32'h24)] || to) begin n_fail++; $display("FAIL bp_not_committed: got %h expected %h", d, model[widx(32'h24)]); end
        bready = 1'b1;
        @(negedge aclk);
        n_tests++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL bp_b_accepted: got %b expected 0", bvalid); end
        @(negedge aclk);
        model_write(32'h24, 32'h77665544, 4'hF, 3'b001);
        n_tests++; if ({bvalid, bresp} !== {1'b1, OKAY}) begin n_fail++; $display("FAIL bp_second_b: got %b expected %b", {bvalid, bresp}, {1'b1, OKAY}); end
        @(negedge aclk);
        axi_read(32'h24, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[widx(32'h24)]) begin n_fail++; $display("FAIL bp_second_data: got %h expected %h", d, model[widx(32'h24)]); end
        // read response held under rready=0
        araddr = 32'h20; arprot = 3'b001; rready = 1'b0; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({rvalid, arready, rresp, rdata} !== {2'b10, OKAY, model[widx(32'h20)]}) begin n_fail++; $display("FAIL bp_r_hold_cycle%0d: got %b/%b/%h expected 1/0/%h", i, rvalid, arready, rdata, model[widx(32'h20)]); end
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        n_tests++; if ({rvalid, arready} !== 2'b01) begin n_fail++; $display("FAIL bp_r_release: got %b expected 01", {rvalid, arready}); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        axi_write(32'h40, 32'h01020304, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h40, 32'h01020304, 4'hF, 3'b001);
        bready = 1'b0;
        axi_write(32'h44, 32'hFEEDFACE, 4'hF, 3'b001, 0, 0, resp, lat, to);
        model_write(32'h44, 32'hFEEDFACE, 4'hF, 3'b001);
        awaddr = 32'h40; wdata = 32'hBBBBBBBB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        araddr = 32'h40; arvalid = 1'b1; rready = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        n_tests++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++; $display("FAIL rstmid_async: got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
        awvalid = 1'b0; arvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_tests++; if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_resp_cycle%0d: got %b expected 00", i, {bvalid, rvalid}); end
        end
        axi_read(32'h40, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[widx(32'h40)] || to) begin n_fail++; $display("FAIL rstmid_word_unchanged: got %h expected %h", d, model[widx(32'h40)]); end
        axi_read(32'h44, 3'b001, d, resp, lat, to);
        n_tests++; if (d !== model[widx(32'h44)] || to) begin n_fail++; $display("FAIL rstmid_prior_commit: got %h expected %h", d, model[widx(32'h44)]); end
    endtask

    task automatic test_prot();
        logic [1:0] resp; logic [31:0] d; int lat; bit to;
        logic [2:0] plist [4];
        plist[0] = 3'b001; plist[1] = 3'b000; plist[2] = 3'b001; plist[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            axi_write(32'h80, wd, 4'hF, plist[i], 0, 0, resp, lat, to);
            model_write(32'h80, wd, 4'hF, plist[i]);
            n_tests++; if (resp !== (addr_ok(32'h80, plist[i]) ? OKAY : SLVERR) || to) begin n_fail++; $display("FAIL prot_bresp%0d: got %b awprot %b", i, resp, plist[i]); end
            axi_read(32'h80, plist[3-i], d, resp, lat, to);
            n_tests++; if ({d, resp} !== (addr_ok(32'h80, plist[3-i]) ? {model[widx(32'h80)], OKAY} : {32'h0, SLVERR})) begin n_fail++; $display("FAIL prot_read%0d: got %h/%b arprot %b expected data %h", i, d, resp, plist[3-i], model[widx(32'h80)]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [31:0] d, a, wd; logic [3:0] s; logic [2:0] p; int lat, idx; bit to;
        for (int i = 0; i < 16; i++) begin
            idx = (i < 8) ? i : DEPTH - 16 + i;
            wd = $urandom;
            axi_write(32'(idx * 4), wd, 4'hF, 3'b001, 0, 0, resp, lat, to);
            model_write(32'(idx * 4), wd, 4'hF, 3'b001);
        end
        for (int i = 0; i < 80; i++) begin
            int pick;
            pick = int'($urandom_range(0, 15));
            idx = (pick < 8) ? pick : DEPTH - 16 + pick;
            a = 32'(idx * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH * 4) * 32'($urandom_range(1, 3));
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, wd, s, p, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, lat, to);
                model_write(a, wd, s, p);
                n_tests++; if (resp !== (addr_ok(a, p) ? OKAY : SLVERR) || to) begin n_fail++; $display("FAIL rand_bresp%0d: addr %h prot %b got %b", i, a, p, resp); end
            end else begin
                axi_read(a, p, d, resp, lat, to);
                n_tests++; if ({d, resp} !== (addr_ok(a, p) ? {model[widx(a)], OKAY} : {32'h0, SLVERR}) || to) begin n_fail++; $display("FAIL rand_read%0d: addr %h prot %b got %h/%b expected data %h", i, a, p, d, resp, model[widx(a)]); end
            end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b1;
        arvalid = 1'b0; araddr = '0; arprot = '0;
        rready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        test_reset();
        test_basic();
        test_strobe();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_prot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
